// File: rtl/prestep_scheduler.sv
// Walks the active contacts once per physics step: fetch operands, restart the pre-step
// datapath, wait for completion, commit results. Optional skip support: PRESTEP_SCHED_SKIP_EN.
module prestep_scheduler #(
    parameter int MAX_CONTACTS = 64,
    parameter int AW           = 6,
    parameter int TIMEOUT      = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_contacts,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ct_rd_en,
    output logic [AW-1:0] ct_rd_addr,
    input  logic          ct_rd_valid,
    input  logic          ct_skip,
    output logic          ps_rst,
    input  logic          ps_done,
    output logic          res_wr_en,
    output logic [AW-1:0] res_wr_addr,
    output logic [2:0]    dbg_state
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   MAX_N = (AW + 1)'(MAX_CONTACTS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_KICK      = 3'd3,
        S_RUN       = 3'd4,
        S_WRITE     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [AW-1:0] idx, idx_d;
    logic [AW:0]   n_q, n_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          err_q, err_d;
    logic [AW:0]   n_clamp;
    logic          last;

    assign n_clamp = (num_contacts > MAX_N) ? MAX_N : num_contacts;
    // n_q is at least 1 whenever this is consulted, so the subtraction cannot underflow.
    assign last    = ({1'b0, idx} == (n_q - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            n_q   <= '0;
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            n_q   <= n_d;
            tcnt  <= tcnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        n_d     = n_q;
        tcnt_d  = tcnt;
        err_d   = err_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_clamp;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (n_clamp == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
`ifdef PRESTEP_SCHED_SKIP_EN
                if (ct_rd_valid && ct_skip) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (ct_rd_valid) begin
                    state_d = S_KICK;
                end
`else
                if (ct_rd_valid) state_d = S_KICK;
`endif
            end
            S_KICK: begin
                tcnt_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ps_done) begin
                    state_d = S_WRITE;
                end else if (tcnt == T_LAST) begin
                    // This RUN cycle is the TIMEOUT-th without completion: abort the pass.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            S_WRITE: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifndef PRESTEP_SCHED_SKIP_EN
    logic unused_skip;
    assign unused_skip = ct_skip;
`endif

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign err         = err_q;
    assign ct_rd_en    = (state == S_FETCH);
    assign ps_rst      = (state == S_KICK);
    assign res_wr_en   = (state == S_WRITE);
    assign ct_rd_addr  = idx;
    assign res_wr_addr = idx;
    assign dbg_state   = state;

endmodule

// File: tb/tb_prestep_scheduler.sv
// Directed bench for prestep_scheduler: operand-memory and 7-step datapath models,
// read/write address scoreboards popped by a monitor, and per-pass timing checks.
module tb_prestep_scheduler;

    localparam int AW = 6;

    // Handshake: ct_rd_valid pulses the cycle after ct_rd_en; ps_done is a level that
    // rises 7 cycles after ps_rst falls and stays up until the next ps_rst.

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_contacts = '0;
    logic          busy, done, err, ct_rd_en, ps_rst, res_wr_en;
    logic [AW-1:0] ct_rd_addr, res_wr_addr;
    logic          ct_rd_valid, ct_skip, ps_done;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int ps_rst_cnt = 0;
    int hang_addr = -1;
    int skip_addr = -1;
    int dp_cnt;

    logic [AW-1:0] rd_exp_q[$];
    logic [AW-1:0] wr_exp_q[$];

    prestep_scheduler #(.MAX_CONTACTS(64), .AW(AW), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .start(start), .num_contacts(num_contacts),
        .busy(busy), .done(done), .err(err),
        .ct_rd_en(ct_rd_en), .ct_rd_addr(ct_rd_addr), .ct_rd_valid(ct_rd_valid),
        .ct_skip(ct_skip), .ps_rst(ps_rst), .ps_done(ps_done),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Operand memory with one-cycle read latency.
    always @(posedge clk or posedge rst) begin
        if (rst) ct_rd_valid <= 1'b0;
        else     ct_rd_valid <= ct_rd_en;
    end
    assign ct_skip = ct_rd_valid && (skip_addr >= 0) && (int'(ct_rd_addr) == skip_addr);

    // Pre-step datapath: 7 steps after restart, optionally hung on one contact.
    always @(posedge clk or posedge rst) begin
        if (rst)             dp_cnt <= 0;
        else if (ps_rst)     dp_cnt <= 0;
        else if (dp_cnt < 7) dp_cnt <= dp_cnt + 1;
    end
    assign ps_done = (dp_cnt == 7) && !((hang_addr >= 0) && (int'(ct_rd_addr) == hang_addr));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected address whenever a read or write strobe is seen.
    always @(negedge clk) begin
        if (!rst) begin
            if (ct_rd_en) begin
                if (rd_exp_q.size() == 0) check("rd_unexpected", int'(ct_rd_addr), -1);
                else check("rd_addr", int'(ct_rd_addr), int'(rd_exp_q.pop_front()));
            end
            if (res_wr_en) begin
                if (wr_exp_q.size() == 0) check("wr_unexpected", int'(res_wr_addr), -1);
                else check("wr_addr", int'(res_wr_addr), int'(wr_exp_q.pop_front()));
            end
            if (ps_rst) ps_rst_cnt++;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_rd_en"}, int'(ct_rd_en), 0);
        check({tag, "_ps_rst"}, int'(ps_rst), 0);
        check({tag, "_wr_en"}, int'(res_wr_en), 0);
        check({tag, "_rd_addr"}, int'(ct_rd_addr), 0);
        check({tag, "_wr_addr"}, int'(res_wr_addr), 0);
    endtask

    // Runs one pass. exp_done is the cycle (after the start-sampling edge) in which done is high.
    task automatic run_pass(input string tag, input int n_in, input int hang, input int skip,
                            input int exp_done, input int exp_err, input bit mid_start);
        int nn, ps_exp, got;
        bit skipped;
        hang_addr = hang;
        skip_addr = skip;
        nn = (n_in > 64) ? 64 : n_in;
        ps_exp = 0;
        for (int i = 0; i < nn; i++) begin
            rd_exp_q.push_back(AW'(i));
            skipped = 1'b0;
`ifdef PRESTEP_SCHED_SKIP_EN
            skipped = (i == skip);
`endif
            if (!skipped) begin
                ps_exp++;
                if (i == hang) break;
                wr_exp_q.push_back(AW'(i));
            end
        end
        ps_rst_cnt = 0;
        @(negedge clk);
        num_contacts = (AW + 1)'(n_in);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_err_cleared"}, int'(err), 0);
                check({tag, "_busy_c1"}, int'(busy), 1);
            end
            if (mid_start && k == 20) begin
                num_contacts = 7'd1;
                start = 1'b1;
            end
            if (mid_start && k == 21) start = 1'b0;
            if (done) begin
                got = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, got, exp_done);
        check({tag, "_err"}, int'(err), exp_err);
        @(negedge clk);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_ps_rst_count"}, ps_rst_cnt, ps_exp);
        check({tag, "_rd_left"}, rd_exp_q.size(), 0);
        check({tag, "_wr_left"}, wr_exp_q.size(), 0);
        rd_exp_q.delete();
        wr_exp_q.delete();
        hang_addr = -1;
        skip_addr = -1;
    endtask

    initial begin
        int found;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_pass("n1", 1, -1, -1, 13, 0, 1'b0);
        run_pass("n3", 3, -1, -1, 37, 0, 1'b1);
        run_pass("n0", 0, -1, -1, 1, 0, 1'b0);
        run_pass("n100", 100, -1, -1, 769, 0, 1'b0);
        run_pass("timeout", 3, 1, -1, 47, 1, 1'b0);
        run_pass("after_to", 1, -1, -1, 13, 0, 1'b0);
`ifdef PRESTEP_SCHED_SKIP_EN
        run_pass("skip", 3, -1, 1, 27, 0, 1'b0);
`else
        run_pass("skip", 3, -1, 1, 37, 0, 1'b0);
`endif

        // Reset during RUN of the second contact.
        rd_exp_q.push_back(6'd0);
        rd_exp_q.push_back(6'd1);
        wr_exp_q.push_back(6'd0);
        ps_rst_cnt = 0;
        @(negedge clk);
        num_contacts = 7'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dbg_state == 3'd4 && ct_rd_addr == 6'd1) begin
                found = 1;
                break;
            end
        end
        check("rst_reached_run2", found, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs("mid_rst");
        check("mid_rst_state", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("post_rst");
        check("rst_ps_rst_count", ps_rst_cnt, 2);
        check("rst_rd_left", rd_exp_q.size(), 0);
        check("rst_wr_left", wr_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
